// File: rtl/riscv_decode_stage_pkg.sv
// Shared types for the decode stage: ALU function and branch encodings, opcodes,
// the decoded-instruction record and the combinational instruction decoder.
package riscv_decode_stage_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [9:0] {
    ALU_ADD  = 10'h000,
    ALU_SLL  = 10'h001,
    ALU_SLT  = 10'h002,
    ALU_SLTU = 10'h003,
    ALU_XOR  = 10'h004,
    ALU_SRL  = 10'h005,
    ALU_OR   = 10'h006,
    ALU_AND  = 10'h007,
    ALU_SUB  = 10'h100,
    ALU_SRA  = 10'h105
  } alu_func_t;

  // BR_NONE reuses funct3 010, which is never a legal branch
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_NONE = 3'b010,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_t;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            use_imm;
    logic            shift_from_rs2;
    logic            rd_we;
    logic            illegal;
    alu_func_t       alu_func;
    branch_t         branch;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] br_off;
    logic [4:0]      shift_imm;
  } decoded_t;

  function automatic decoded_t decode_instr(input logic [31:0] instr);
    decoded_t   d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = instr[31:25];
    f3 = instr[14:12];
    d = '0;
    d.alu_func = ALU_ADD;
    d.branch   = BR_NONE;
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    case (instr[6:0])
      OP_R: begin
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
          d.alu_func       = alu_func_t'({f7, f3});
          d.use_rs1        = 1'b1;
          d.use_rs2        = 1'b1;
          d.shift_from_rs2 = 1'b1;
          d.rd             = instr[11:7];
          d.rd_we          = 1'b1;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OP_I: begin
        if ((f3 == 3'b001 && f7 != F7_BASE) ||
            (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)) begin
          d.illegal = 1'b1;
        end else begin
          d.alu_func  = alu_func_t'((f3 == 3'b101) ? {f7, f3} : {7'h00, f3});
          d.use_rs1   = 1'b1;
          d.use_imm   = 1'b1;
          d.imm_i     = {{20{instr[31]}}, instr[31:20]};
          d.shift_imm = instr[24:20];
          d.rd        = instr[11:7];
          d.rd_we     = 1'b1;
        end
      end
      OP_SB: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          d.illegal = 1'b1;
        end else begin
          d.alu_func = ALU_SUB;
          d.branch   = branch_t'(f3);
          d.use_rs1  = 1'b1;
          d.use_rs2  = 1'b1;
          d.br_off   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/riscv_decode_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// x0 reads as zero and a same-cycle write is forwarded to the read ports.
module riscv_regfile
  import riscv_decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != 5'd0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? '0 : (we && waddr == raddr1) ? wdata : regs_q[raddr1];
    rdata2 = (raddr2 == 5'd0) ? '0 : (we && waddr == raddr2) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode/operand-fetch stage feeding riscv_alu: decodes R, I-ALU and SB instructions,
// reads operands, stalls on RAW hazards via a scoreboard and registers the ALU entry.
module riscv_decode_stage
  import riscv_decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_shift,
  output alu_func_t       out_alu_func,
  output branch_t         out_branch,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_pc,
  output logic            out_illegal
);

  decoded_t        dec;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            hazard, accept;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_a_q, out_a_d, out_b_q, out_b_d, out_imm_q, out_imm_d;
  logic [4:0]      out_shift_q, out_shift_d, out_rd_q, out_rd_d;
  alu_func_t       out_alu_func_q, out_alu_func_d;
  branch_t         out_branch_q, out_branch_d;
  logic            out_rd_we_q, out_rd_we_d, out_illegal_q, out_illegal_d;
  logic [31:0]     out_pc_q, out_pc_d;

  assign dec = decode_instr(in_instr);

  riscv_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (dec.rs1),
    .rdata1 (rs1_val),
    .raddr2 (dec.rs2),
    .rdata2 (rs2_val)
  );

  // A pending source is fine if its writeback arrives this cycle (it is bypassed)
  always_comb begin
    hazard = 1'b0;
    if (dec.use_rs1 && dec.rs1 != 5'd0 && pending_q[dec.rs1] && !(wb_en && wb_rd == dec.rs1))
      hazard = 1'b1;
    if (dec.use_rs2 && dec.rs2 != 5'd0 && pending_q[dec.rs2] && !(wb_en && wb_rd == dec.rs2))
      hazard = 1'b1;
  end

  assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Set is applied last so a same-cycle set of the cleared rd wins
  always_comb begin
    pending_d = pending_q;
    if (wb_en && wb_rd != 5'd0) pending_d[wb_rd] = 1'b0;
    if (flush && out_valid_q && out_rd_we_q) pending_d[out_rd_q] = 1'b0;
    if (accept && dec.rd_we && dec.rd != 5'd0) pending_d[dec.rd] = 1'b1;
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_a_d        = out_a_q;
    out_b_d        = out_b_q;
    out_shift_d    = out_shift_q;
    out_alu_func_d = out_alu_func_q;
    out_branch_d   = out_branch_q;
    out_rd_d       = out_rd_q;
    out_rd_we_d    = out_rd_we_q;
    out_imm_d      = out_imm_q;
    out_pc_d       = out_pc_q;
    out_illegal_d  = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d    = 1'b1;
      out_a_d        = dec.use_rs1 ? rs1_val : '0;
      out_b_d        = dec.use_imm ? dec.imm_i : (dec.use_rs2 ? rs2_val : '0);
      out_shift_d    = dec.shift_from_rs2 ? rs2_val[4:0] : dec.shift_imm;
      out_alu_func_d = dec.alu_func;
      out_branch_d   = dec.branch;
      out_rd_d       = dec.rd;
      out_rd_we_d    = dec.rd_we;
      out_imm_d      = dec.br_off;
      out_pc_d       = in_pc;
      out_illegal_d  = dec.illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q      <= '0;
      out_valid_q    <= 1'b0;
      out_a_q        <= '0;
      out_b_q        <= '0;
      out_shift_q    <= '0;
      out_alu_func_q <= ALU_ADD;
      out_branch_q   <= BR_NONE;
      out_rd_q       <= '0;
      out_rd_we_q    <= 1'b0;
      out_imm_q      <= '0;
      out_pc_q       <= '0;
      out_illegal_q  <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      out_valid_q    <= out_valid_d;
      out_a_q        <= out_a_d;
      out_b_q        <= out_b_d;
      out_shift_q    <= out_shift_d;
      out_alu_func_q <= out_alu_func_d;
      out_branch_q   <= out_branch_d;
      out_rd_q       <= out_rd_d;
      out_rd_we_q    <= out_rd_we_d;
      out_imm_q      <= out_imm_d;
      out_pc_q       <= out_pc_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_a        = out_a_q;
  assign out_b        = out_b_q;
  assign out_shift    = out_shift_q;
  assign out_alu_func = out_alu_func_q;
  assign out_branch   = out_branch_q;
  assign out_rd       = out_rd_q;
  assign out_rd_we    = out_rd_we_q;
  assign out_imm      = out_imm_q;
  assign out_pc       = out_pc_q;
  assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: a decode vector table plus hand-written
// sequences for hazard stall, backpressure, flush and mid-run reset.
module tb_riscv_decode_stage;
  import riscv_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b, out_imm, out_pc;
  logic [4:0]  out_shift, out_rd;
  alu_func_t   out_alu_func;
  branch_t     out_branch;
  logic        out_rd_we, out_illegal;

  int checks = 0;
  int fails  = 0;

  riscv_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_shift(out_shift), .out_alu_func(out_alu_func),
    .out_branch(out_branch), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  func;
    logic [2:0]  br;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shift;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        illegal;
    logic        chk_ab;
    logic        chk_sh;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] sb_type(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
    tick();
    wb_en   = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{r_type(7'h20, 5'd5, 5'd4, 3'b000, 5'd3), 10'h100, 3'b010, 32'd9, 32'd2, 5'd2, 5'd3, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{i_type(12'h403, 5'd7, 3'b101, 5'd6), 10'h105, 3'b010, 32'hF0000000, 32'h403, 5'd3, 5'd6, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{i_type(12'h021, 5'd10, 3'b001, 5'd13), 10'h000, 3'b010, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{sb_type(13'h1FF8, 5'd2, 5'd1, 3'b110), 10'h100, 3'b110, 32'd5, 32'd10, 5'd0, 5'd0, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{i_type(12'hFFF, 5'd10, 3'b000, 5'd14), 10'h000, 3'b010, 32'd100, 32'hFFFFFFFF, 5'd31, 5'd14, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{r_type(7'h00, 5'd11, 5'd10, 3'b100, 5'd15), 10'h004, 3'b010, 32'd100, 32'd3, 5'd3, 5'd15, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{r_type(7'h20, 5'd11, 5'd12, 3'b101, 5'd16), 10'h105, 3'b010, 32'hFFFFFFFF, 32'd3, 5'd3, 5'd16, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{r_type(7'h20, 5'd11, 5'd10, 3'b001, 5'd19), 10'h000, 3'b010, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{sb_type(13'd16, 5'd11, 5'd10, 3'b101), 10'h100, 3'b101, 32'd100, 32'd3, 5'd0, 5'd0, 1'b0, 32'd16, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{sb_type(13'd16, 5'd11, 5'd10, 3'b010), 10'h000, 3'b010, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{{12'h000, 5'd10, 3'b010, 5'd3, 7'b0000011}, 10'h000, 3'b010, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{i_type(12'h800, 5'd11, 3'b011, 5'd17), 10'h003, 3'b010, 32'd3, 32'hFFFFF800, 5'd0, 5'd17, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{i_type(12'h004, 5'd12, 3'b101, 5'd18), 10'h005, 3'b010, 32'hFFFFFFFF, 32'd4, 5'd4, 5'd18, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{r_type(7'h01, 5'd11, 5'd10, 3'b000, 5'd20), 10'h000, 3'b010, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    #12;
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.alu_func", 32'(out_alu_func), 32'(ALU_ADD));
    checkOutput("reset.branch", 32'(out_branch), 32'(BR_NONE));
    checkOutput("reset.out_a", out_a, 32'd0);
    checkOutput("reset.rd_we", 32'(out_rd_we), 32'd0);
    rst = 1'b0;
    tick();

    // ADDI x1,x0,5 then ADD x2,x1,x1 stalled until writeback of x1
    applyStimulus(1'b1, i_type(12'd5, 5'd0, 3'b000, 5'd1), 32'h100);
    tick();
    checkOutput("addi.valid", 32'(out_valid), 32'd1);
    checkOutput("addi.b", out_b, 32'd5);
    checkOutput("addi.rd", 32'(out_rd), 32'd1);
    applyStimulus(1'b1, r_type(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'h104);
    #1 checkOutput("raw.stall0", 32'(in_ready), 32'd0);
    tick();
    checkOutput("raw.stall1", 32'(in_ready), 32'd0);
    checkOutput("raw.bubble", 32'(out_valid), 32'd0);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    #1 checkOutput("raw.release", 32'(in_ready), 32'd1);
    tick();
    wb_en = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("raw.valid", 32'(out_valid), 32'd1);
    checkOutput("raw.a", out_a, 32'd5);
    checkOutput("raw.b", out_b, 32'd5);
    checkOutput("raw.func", 32'(out_alu_func), 32'(ALU_ADD));
    checkOutput("raw.rd", 32'(out_rd), 32'd2);
    writeback(5'd2, 32'd10);

    writeback(5'd4, 32'd9);
    writeback(5'd5, 32'd2);
    writeback(5'd7, 32'hF0000000);
    writeback(5'd10, 32'd100);
    writeback(5'd11, 32'd3);
    writeback(5'd12, 32'hFFFFFFFF);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4));
      #1 checkOutput($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0);
      checkOutput($sformatf("v%0d.valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("v%0d.pc", i), out_pc, 32'h1000 + 32'(i * 4));
      checkOutput($sformatf("v%0d.func", i), 32'(out_alu_func), 32'(vecs[i].func));
      checkOutput($sformatf("v%0d.branch", i), 32'(out_branch), 32'(vecs[i].br));
      checkOutput($sformatf("v%0d.rd_we", i), 32'(out_rd_we), 32'(vecs[i].rd_we));
      checkOutput($sformatf("v%0d.imm", i), out_imm, vecs[i].imm);
      checkOutput($sformatf("v%0d.illegal", i), 32'(out_illegal), 32'(vecs[i].illegal));
      if (vecs[i].chk_ab) begin
        checkOutput($sformatf("v%0d.a", i), out_a, vecs[i].a);
        checkOutput($sformatf("v%0d.b", i), out_b, vecs[i].b);
      end
      if (vecs[i].chk_sh) checkOutput($sformatf("v%0d.shift", i), 32'(out_shift), 32'(vecs[i].shift));
      if (vecs[i].rd_we) checkOutput($sformatf("v%0d.rd", i), 32'(out_rd), 32'(vecs[i].rd));
    end

    // BLTU's rd field was 25: it must not have been marked pending
    applyStimulus(1'b1, r_type(7'h00, 5'd0, 5'd25, 3'b000, 5'd22), 32'h200);
    #1 checkOutput("bltu.no_pending", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    writeback(5'd22, 32'd0);

    // backpressure: held entry stable, next instruction neither lost nor duplicated
    out_ready = 1'b0;
    applyStimulus(1'b1, i_type(12'd1, 5'd10, 3'b000, 5'd20), 32'h300);
    tick();
    applyStimulus(1'b1, i_type(12'd2, 5'd10, 3'b000, 5'd21), 32'h304);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp%0d.in_ready", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp%0d.valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp%0d.rd", c), 32'(out_rd), 32'd20);
      checkOutput($sformatf("bp%0d.a", c), out_a, 32'd100);
      checkOutput($sformatf("bp%0d.b", c), out_b, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1 checkOutput("bp.release", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("bp.next_rd", 32'(out_rd), 32'd21);
    checkOutput("bp.next_b", out_b, 32'd2);
    checkOutput("bp.next_pc", out_pc, 32'h304);
    tick();
    checkOutput("bp.drained", 32'(out_valid), 32'd0);
    writeback(5'd20, 32'd0);
    writeback(5'd21, 32'd0);

    // flush of held ADDI x8, with a writeback of x23 committing in the flush cycle
    out_ready = 1'b0;
    applyStimulus(1'b1, i_type(12'd7, 5'd0, 3'b000, 5'd8), 32'h400);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("flush.held_rd", 32'(out_rd), 32'd8);
    flush = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd23; wb_data = 32'h55;
    #1 checkOutput("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; wb_en = 1'b0;
    checkOutput("flush.valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    applyStimulus(1'b1, r_type(7'h00, 5'd23, 5'd8, 3'b000, 5'd9), 32'h404);
    #1 checkOutput("flush.no_stall", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("flush.add_valid", 32'(out_valid), 32'd1);
    checkOutput("flush.add_a", out_a, 32'd0);
    checkOutput("flush.add_b", out_b, 32'h55);
    writeback(5'd9, 32'd0);

    // reset while an entry is held discards it and clears scoreboard and registers
    out_ready = 1'b0;
    applyStimulus(1'b1, i_type(12'd1, 5'd10, 3'b000, 5'd26), 32'h500);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("rst.held", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.rd", 32'(out_rd), 32'd0);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    applyStimulus(1'b1, r_type(7'h00, 5'd26, 5'd10, 3'b000, 5'd27), 32'h504);
    #1 checkOutput("rst.no_pending", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("rst.regfile_a", out_a, 32'd0);
    checkOutput("rst.regfile_b", out_b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
